aq_axis_t64f32: RTL and testbench
=================================

Name: aq_axis_t64f32

Overview:
- Upstream packer that feeds the 64-to-32 AXI-Stream splitter. Accepts 32-bit AXIS beats and packs pairs into 64-bit beats.
- First accepted beat of a pair goes to the low half, second to the high half (default order).
- A packet ending on a low half is closed with a padded high half (TSTRB[7:4]=0).
- The output is fully registered, so it can drive the splitter directly without a combinational path on data/valid.

Parameters:
- PAD_DATA, 32'h0000_0000, data value placed in the unused half when TLAST arrives on the first beat of a pair.

Ports:
- I_AXIS_TCLK  in  1  single clock for the whole block (both sides)
- ARESETN  in  1  synchronous reset, active-low, sampled on rising I_AXIS_TCLK
- I_AXIS_TDATA  in  32  input data
- I_AXIS_TVALID  in  1  input valid
- I_AXIS_TREADY  out  1  input ready
- I_AXIS_TSTRB  in  4  input byte strobes
- I_AXIS_TKEEP  in  1  input keep
- I_AXIS_TLAST  in  1  input end of packet
- O_AXIS_TCLK  out  1  equals I_AXIS_TCLK
- O_AXIS_TDATA  out  64  packed data, registered
- O_AXIS_TVALID  out  1  output valid, registered
- O_AXIS_TREADY  in  1  output ready
- O_AXIS_TSTRB  out  8  packed strobes, registered
- O_AXIS_TKEEP  out  1  AND of the TKEEP values of the contributing beats, registered
- O_AXIS_TLAST  out  1  TLAST of the last contributing beat, registered

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: all registers 0, O_AXIS_TVALID=0, state=EMPTY. I_AXIS_TREADY is forced 0 while ARESETN=0.
- Reset mid-packet: any half-assembled word is discarded; no flush word is emitted.
- Internal state:
  - lo_data[31:0], lo_strb[3:0], lo_keep hold the first beat of a pair.
  - The output register holds data, strb, keep, last and valid.
- Definitions:
  - out_free = ~O_AXIS_TVALID | O_AXIS_TREADY (output register can load this cycle).
  - acc = I_AXIS_TVALID & I_AXIS_TREADY.
- States: EMPTY, HALF, PAD.
  - EMPTY: I_AXIS_TREADY=1.
    - acc & ~TLAST: capture lo_*, go to HALF.
    - acc & TLAST & out_free: load output {PAD_DATA, TDATA}, strb {4'b0, TSTRB}, last=1. Stay in EMPTY.
    - acc & TLAST & ~out_free: capture lo_*, go to PAD.
  - HALF: I_AXIS_TREADY=out_free.
    - On acc: load output {TDATA, lo_data}, strb {TSTRB, lo_strb}, keep = lo_keep & TKEEP, last = TLAST. Go to EMPTY.
  - PAD: I_AXIS_TREADY=0.
    - When out_free: load output {PAD_DATA, lo_data}, strb {4'b0, lo_strb}, last=1. Go to EMPTY.
- Output valid:
  - O_AXIS_TVALID sets on the cycle after any output load.
  - It clears on O_AXIS_TVALID & O_AXIS_TREADY when no load happens the same cycle.
  - A simultaneous drain and load keeps valid at 1 with the new data.
- Latency and throughput:
  - Latency is 1 cycle from acceptance of the completing input beat to O_AXIS_TVALID.
  - Sustained rate is one output beat per two input beats, with no bubbles when O_AXIS_TREADY is held at 1.
- Paths and protocol:
  - The only combinational path is O_AXIS_TREADY to I_AXIS_TREADY, in HALF state only.
  - Output data, strb, keep and last stay stable while O_AXIS_TVALID=1 & ~O_AXIS_TREADY.
  - I_AXIS_TREADY does not depend on I_AXIS_TVALID or I_AXIS_TLAST.
  - Input beats with TSTRB=0 are still packed; no beat is dropped.

Optional Feature:
- Macro: AQ_AXIS_T64F32_HI_FIRST_EN.
- Defined: the first beat of a pair goes to [63:32] and the second to [31:0], with strobes swapped to match.
  - A padded word becomes {lo_data, PAD_DATA}, strb {lo_strb, 4'b0}.
  - This matches a downstream splitter that emits the upper half first.
- Undefined: default order (first beat in the low half), as described above.

Decomposition:
- Package aq_axis_pkg holds:
  - state typedef (EMPTY/HALF/PAD);
  - localparams for widths: NARROW_W=32, WIDE_W=64, NARROW_STRB_W=4, WIDE_STRB_W=8.
- One sub-module, aq_axis_oreg: the output register slice (load, drain, valid tracking, out_free). It is reused by other aq_axis converters.

Test Plan:
- Continuous packing: input 11111111, 22222222 (TLAST=1), O_AXIS_TREADY=1 -> one output 2222222211111111, TSTRB=FF, TLAST=1, one cycle after the second beat.
- Odd-length packet: 3 beats A0000001, A0000002, A0000003 (last), strb F each -> A0000002A0000001 strb FF last=0, then 00000000A0000003 strb 0F last=1.
- Backpressure: O_AXIS_TREADY=0 for 5 cycles after the first word.
  - Output held stable.
  - I_AXIS_TREADY=0 in HALF.
  - No input loss once O_AXIS_TREADY returns to 1.
- PAD path: single-beat packet 55555555 (last) while the output register is full and stalled -> state PAD, I_AXIS_TREADY=0; after the drain, 0000000055555555 strb 0F last=1.
- Reset mid-pair: accept 12345678, then pull ARESETN low for 1 cycle -> O_AXIS_TVALID=0; the next pair 9ABCDEF0, 0FEDCBA9 outputs 0FEDCBA99ABCDEF0 with no trace of 12345678.
- HI_FIRST_EN build: input 11111111, 22222222 -> 1111111122222222; odd last beat 33333333 -> 3333333300000000, strb F0.

Source files
------------

// File: rtl/aq_axis_pkg.sv
// Shared types and widths for the aq_axis stream converters.
// Holds the packer state encoding and the narrow/wide bus widths.
package aq_axis_pkg;

    localparam int NARROW_W      = 32;
    localparam int WIDE_W        = 64;
    localparam int NARROW_STRB_W = 4;
    localparam int WIDE_STRB_W   = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        PAD   = 2'd2
    } state_t;

endpackage

// File: rtl/aq_axis_oreg.sv
// Output register slice for the aq_axis converters.
// Holds one wide beat; reloads on the same cycle it drains.
module aq_axis_oreg
    import aq_axis_pkg::*;
#(
    parameter int DATA_W = WIDE_W,
    parameter int STRB_W = WIDE_STRB_W
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [STRB_W-1:0] ld_strb,
    input  logic              ld_keep,
    input  logic              ld_last,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    output logic [STRB_W-1:0] tstrb,
    output logic              tkeep,
    output logic              tlast,
    output logic              out_free
);

    assign out_free = ~tvalid | tready;

    // Load a new beat, or drop valid once the current beat is taken.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tdata  <= '0;
            tstrb  <= '0;
            tkeep  <= 1'b0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
        end else if (ld) begin
            tdata  <= ld_data;
            tstrb  <= ld_strb;
            tkeep  <= ld_keep;
            tlast  <= ld_last;
            tvalid <= 1'b1;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/aq_axis_t64f32.sv
// Packs pairs of 32-bit AXIS beats into registered 64-bit beats.
// Define AQ_AXIS_T64F32_HI_FIRST_EN to place the first beat in [63:32].
module aq_axis_t64f32
    import aq_axis_pkg::*;
#(
    parameter logic [NARROW_W-1:0] PAD_DATA = 32'h0000_0000
) (
    input  logic                     I_AXIS_TCLK,
    input  logic                     ARESETN,
    input  logic [NARROW_W-1:0]      I_AXIS_TDATA,
    input  logic                     I_AXIS_TVALID,
    output logic                     I_AXIS_TREADY,
    input  logic [NARROW_STRB_W-1:0] I_AXIS_TSTRB,
    input  logic                     I_AXIS_TKEEP,
    input  logic                     I_AXIS_TLAST,
    output logic                     O_AXIS_TCLK,
    output logic [WIDE_W-1:0]        O_AXIS_TDATA,
    output logic                     O_AXIS_TVALID,
    input  logic                     O_AXIS_TREADY,
    output logic [WIDE_STRB_W-1:0]   O_AXIS_TSTRB,
    output logic                     O_AXIS_TKEEP,
    output logic                     O_AXIS_TLAST
);

    state_t                   state;
    state_t                   state_nxt;
    logic [NARROW_W-1:0]      lo_data;
    logic [NARROW_STRB_W-1:0] lo_strb;
    logic                     lo_keep;
    logic                     lo_ld;

    logic                     out_free;
    logic                     acc;
    logic                     ld;
    logic [NARROW_W-1:0]      first_d;
    logic [NARROW_W-1:0]      second_d;
    logic [NARROW_STRB_W-1:0] first_s;
    logic [NARROW_STRB_W-1:0] second_s;
    logic                     ld_keep;
    logic                     ld_last;
    logic [WIDE_W-1:0]        ld_data;
    logic [WIDE_STRB_W-1:0]   ld_strb;

    assign O_AXIS_TCLK = I_AXIS_TCLK;

    assign I_AXIS_TREADY = ARESETN &
        ((state == EMPTY) | ((state == HALF) & out_free));

    assign acc = I_AXIS_TVALID & I_AXIS_TREADY;

`ifdef AQ_AXIS_T64F32_HI_FIRST_EN
    assign ld_data = {first_d, second_d};
    assign ld_strb = {first_s, second_s};
`else
    assign ld_data = {second_d, first_d};
    assign ld_strb = {second_s, first_s};
`endif

    // Next state and output-load selection.
    always_comb begin
        state_nxt = state;
        lo_ld     = 1'b0;
        ld        = 1'b0;
        first_d   = I_AXIS_TDATA;
        first_s   = I_AXIS_TSTRB;
        second_d  = PAD_DATA;
        second_s  = '0;
        ld_keep   = I_AXIS_TKEEP;
        ld_last   = 1'b1;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    if (!I_AXIS_TLAST) begin
                        lo_ld     = 1'b1;
                        state_nxt = HALF;
                    end else if (out_free) begin
                        ld = 1'b1;
                    end else begin
                        lo_ld     = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            HALF: begin
                if (acc) begin
                    ld        = 1'b1;
                    first_d   = lo_data;
                    first_s   = lo_strb;
                    second_d  = I_AXIS_TDATA;
                    second_s  = I_AXIS_TSTRB;
                    ld_keep   = lo_keep & I_AXIS_TKEEP;
                    ld_last   = I_AXIS_TLAST;
                    state_nxt = EMPTY;
                end
            end
            PAD: begin
                if (out_free) begin
                    ld        = 1'b1;
                    first_d   = lo_data;
                    first_s   = lo_strb;
                    ld_keep   = lo_keep;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State register and holding slot for the first beat of a pair.
    always_ff @(posedge I_AXIS_TCLK) begin
        if (!ARESETN) begin
            state   <= EMPTY;
            lo_data <= '0;
            lo_strb <= '0;
            lo_keep <= 1'b0;
        end else begin
            state <= state_nxt;
            if (lo_ld) begin
                lo_data <= I_AXIS_TDATA;
                lo_strb <= I_AXIS_TSTRB;
                lo_keep <= I_AXIS_TKEEP;
            end
        end
    end

    aq_axis_oreg #(
        .DATA_W (WIDE_W),
        .STRB_W (WIDE_STRB_W)
    ) u_oreg (
        .clk      (I_AXIS_TCLK),
        .aresetn  (ARESETN),
        .ld       (ld),
        .ld_data  (ld_data),
        .ld_strb  (ld_strb),
        .ld_keep  (ld_keep),
        .ld_last  (ld_last),
        .tready   (O_AXIS_TREADY),
        .tdata    (O_AXIS_TDATA),
        .tvalid   (O_AXIS_TVALID),
        .tstrb    (O_AXIS_TSTRB),
        .tkeep    (O_AXIS_TKEEP),
        .tlast    (O_AXIS_TLAST),
        .out_free (out_free)
    );

endmodule

// File: tb/tb_aq_axis_t64f32.sv
// Bench for aq_axis_t64f32: directed table, corner sequences,
// random traffic checked against a pairing scoreboard.
module tb_aq_axis_t64f32;

    logic        clk;
    logic        ARESETN;
    logic [31:0] I_AXIS_TDATA;
    logic        I_AXIS_TVALID;
    logic        I_AXIS_TREADY;
    logic [3:0]  I_AXIS_TSTRB;
    logic        I_AXIS_TKEEP;
    logic        I_AXIS_TLAST;
    logic        O_AXIS_TCLK;
    logic [63:0] O_AXIS_TDATA;
    logic        O_AXIS_TVALID;
    logic        O_AXIS_TREADY;
    logic [7:0]  O_AXIS_TSTRB;
    logic        O_AXIS_TKEEP;
    logic        O_AXIS_TLAST;

    aq_axis_t64f32 dut (
        .I_AXIS_TCLK   (clk),
        .ARESETN       (ARESETN),
        .I_AXIS_TDATA  (I_AXIS_TDATA),
        .I_AXIS_TVALID (I_AXIS_TVALID),
        .I_AXIS_TREADY (I_AXIS_TREADY),
        .I_AXIS_TSTRB  (I_AXIS_TSTRB),
        .I_AXIS_TKEEP  (I_AXIS_TKEEP),
        .I_AXIS_TLAST  (I_AXIS_TLAST),
        .O_AXIS_TCLK   (O_AXIS_TCLK),
        .O_AXIS_TDATA  (O_AXIS_TDATA),
        .O_AXIS_TVALID (O_AXIS_TVALID),
        .O_AXIS_TREADY (O_AXIS_TREADY),
        .O_AXIS_TSTRB  (O_AXIS_TSTRB),
        .O_AXIS_TKEEP  (O_AXIS_TKEEP),
        .O_AXIS_TLAST  (O_AXIS_TLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_ok  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [63:0] w64(input logic [31:0] f,
                                        input logic [31:0] s);
`ifdef AQ_AXIS_T64F32_HI_FIRST_EN
        return {f, s};
`else
        return {s, f};
`endif
    endfunction

    function automatic logic [7:0] w8(input logic [3:0] f,
                                      input logic [3:0] s);
`ifdef AQ_AXIS_T64F32_HI_FIRST_EN
        return {f, s};
`else
        return {s, f};
`endif
    endfunction

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        k;
        logic        l;
    } word_t;

    word_t       q[$];
    logic        have_lo = 1'b0;
    logic [31:0] m_lo_d;
    logic [3:0]  m_lo_s;
    logic        m_lo_k;

    logic        st_v = 1'b0;
    logic [63:0] st_d;
    logic [7:0]  st_s;
    logic        st_k;
    logic        st_l;

    // Scoreboard: pair accepted beats, compare drained words, check hold.
    always @(negedge clk) begin
        word_t w;
        word_t e;
        if (!ARESETN) begin
            q.delete();
            have_lo = 1'b0;
            st_v    = 1'b0;
        end else begin
            if (st_v) begin
                chk("hold_data", O_AXIS_TDATA, st_d);
                chk("hold_ctl",
                    64'({O_AXIS_TVALID, O_AXIS_TSTRB,
                         O_AXIS_TKEEP, O_AXIS_TLAST}),
                    64'({1'b1, st_s, st_k, st_l}));
            end
            st_v = O_AXIS_TVALID & ~O_AXIS_TREADY;
            st_d = O_AXIS_TDATA;
            st_s = O_AXIS_TSTRB;
            st_k = O_AXIS_TKEEP;
            st_l = O_AXIS_TLAST;
            if (O_AXIS_TVALID && O_AXIS_TREADY) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", O_AXIS_TDATA, 64'hX);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", O_AXIS_TDATA, e.d);
                    chk("sb_ctl",
                        64'({O_AXIS_TSTRB, O_AXIS_TKEEP, O_AXIS_TLAST}),
                        64'({e.s, e.k, e.l}));
                end
            end
            if (I_AXIS_TVALID && I_AXIS_TREADY) begin
                if (!have_lo) begin
                    if (I_AXIS_TLAST) begin
                        w.d = w64(I_AXIS_TDATA, 32'h0);
                        w.s = w8(I_AXIS_TSTRB, 4'h0);
                        w.k = I_AXIS_TKEEP;
                        w.l = 1'b1;
                        q.push_back(w);
                    end else begin
                        have_lo = 1'b1;
                        m_lo_d  = I_AXIS_TDATA;
                        m_lo_s  = I_AXIS_TSTRB;
                        m_lo_k  = I_AXIS_TKEEP;
                    end
                end else begin
                    w.d = w64(m_lo_d, I_AXIS_TDATA);
                    w.s = w8(m_lo_s, I_AXIS_TSTRB);
                    w.k = m_lo_k & I_AXIS_TKEEP;
                    w.l = I_AXIS_TLAST;
                    q.push_back(w);
                    have_lo = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] s,
                        input logic k, input logic l);
        int n;
        I_AXIS_TDATA  = d;
        I_AXIS_TSTRB  = s;
        I_AXIS_TKEEP  = k;
        I_AXIS_TLAST  = l;
        I_AXIS_TVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!I_AXIS_TREADY && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        I_AXIS_TVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        k;
        logic        l;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  es;
        logic        ek;
        logic        el;
    } vec_t;

    vec_t tbl[7];
    logic acc_prev;
    int   n;

    initial begin
        tbl[0] = '{32'h11111111, 4'hF, 1'b1, 1'b0, 1'b0,
                   64'h0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{32'h22222222, 4'hF, 1'b1, 1'b1, 1'b1,
                   w64(32'h11111111, 32'h22222222),
                   8'hFF, 1'b1, 1'b1};
        tbl[2] = '{32'hA0000001, 4'hF, 1'b1, 1'b0, 1'b0,
                   64'h0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{32'hA0000002, 4'hF, 1'b1, 1'b0, 1'b1,
                   w64(32'hA0000001, 32'hA0000002),
                   8'hFF, 1'b1, 1'b0};
        tbl[4] = '{32'hA0000003, 4'hF, 1'b1, 1'b1, 1'b1,
                   w64(32'hA0000003, 32'h0),
                   w8(4'hF, 4'h0), 1'b1, 1'b1};
        tbl[5] = '{32'h00000012, 4'h3, 1'b0, 1'b0, 1'b0,
                   64'h0, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{32'h00000034, 4'h0, 1'b1, 1'b1, 1'b1,
                   w64(32'h00000012, 32'h00000034),
                   w8(4'h3, 4'h0), 1'b0, 1'b1};

        ARESETN       = 1'b0;
        I_AXIS_TVALID = 1'b0;
        I_AXIS_TDATA  = '0;
        I_AXIS_TSTRB  = '0;
        I_AXIS_TKEEP  = 1'b0;
        I_AXIS_TLAST  = 1'b0;
        O_AXIS_TREADY = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_iready", 64'(I_AXIS_TREADY), 64'd0);
        chk("rst_ovalid", 64'(O_AXIS_TVALID), 64'd0);
        chk("rst_odata", O_AXIS_TDATA, 64'd0);
        chk("tclk_pass", 64'(O_AXIS_TCLK), 64'(clk));
        @(posedge clk);
        #1;
        ARESETN = 1'b1;
        @(negedge clk);
        chk("post_rst_iready", 64'(I_AXIS_TREADY), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            I_AXIS_TDATA  = tbl[i].d;
            I_AXIS_TSTRB  = tbl[i].s;
            I_AXIS_TKEEP  = tbl[i].k;
            I_AXIS_TLAST  = tbl[i].l;
            I_AXIS_TVALID = 1'b1;
            @(negedge clk);
            chk("tbl_iready", 64'(I_AXIS_TREADY), 64'd1);
            @(posedge clk);
            #1;
            I_AXIS_TVALID = 1'b0;
            @(negedge clk);
            chk("tbl_ovalid", 64'(O_AXIS_TVALID), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_odata", O_AXIS_TDATA, tbl[i].ed);
                chk("tbl_octl",
                    64'({O_AXIS_TSTRB, O_AXIS_TKEEP, O_AXIS_TLAST}),
                    64'({tbl[i].es, tbl[i].ek, tbl[i].el}));
            end
            @(posedge clk);
            #1;
        end

        idle(2);
        O_AXIS_TREADY = 1'b0;
        send(32'hB0000001, 4'hF, 1'b1, 1'b0);
        send(32'hB0000002, 4'hF, 1'b1, 1'b0);
        send(32'hB0000003, 4'hF, 1'b1, 1'b0);
        I_AXIS_TDATA  = 32'hB0000004;
        I_AXIS_TSTRB  = 4'hF;
        I_AXIS_TKEEP  = 1'b1;
        I_AXIS_TLAST  = 1'b1;
        I_AXIS_TVALID = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_iready", 64'(I_AXIS_TREADY), 64'd0);
            chk("bp_ovalid", 64'(O_AXIS_TVALID), 64'd1);
            chk("bp_odata", O_AXIS_TDATA,
                w64(32'hB0000001, 32'hB0000002));
            @(posedge clk);
            #1;
        end
        O_AXIS_TREADY = 1'b1;
        #1;
        chk("bp_iready_back", 64'(I_AXIS_TREADY), 64'd1);
        @(posedge clk);
        #1;
        I_AXIS_TVALID = 1'b0;
        O_AXIS_TREADY = 1'b0;
        @(negedge clk);
        chk("bp_word2", O_AXIS_TDATA, w64(32'hB0000003, 32'hB0000004));
        chk("bp_word2_last", 64'(O_AXIS_TLAST), 64'd1);
        @(posedge clk);
        #1;

        send(32'h55555555, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        chk("pad_iready", 64'(I_AXIS_TREADY), 64'd0);
        chk("pad_hold", O_AXIS_TDATA, w64(32'hB0000003, 32'hB0000004));
        @(posedge clk);
        #1;
        O_AXIS_TREADY = 1'b1;
        #1;
        chk("pad_iready_rdy", 64'(I_AXIS_TREADY), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pad_ovalid", 64'(O_AXIS_TVALID), 64'd1);
        chk("pad_odata", O_AXIS_TDATA, w64(32'h55555555, 32'h0));
        chk("pad_octl", 64'({O_AXIS_TSTRB, O_AXIS_TKEEP, O_AXIS_TLAST}),
            64'({w8(4'hF, 4'h0), 1'b1, 1'b1}));
        @(posedge clk);
        #1;

        idle(2);
        send(32'h12345678, 4'hF, 1'b1, 1'b0);
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_iready", 64'(I_AXIS_TREADY), 64'd0);
        @(posedge clk);
        #1;
        ARESETN = 1'b1;
        @(negedge clk);
        chk("mid_rst_ovalid", 64'(O_AXIS_TVALID), 64'd0);
        chk("mid_rst_iready1", 64'(I_AXIS_TREADY), 64'd1);
        @(posedge clk);
        #1;
        send(32'h9ABCDEF0, 4'hF, 1'b1, 1'b0);
        chk("mid_rst_nolo", 64'(O_AXIS_TVALID), 64'd0);
        send(32'h0FEDCBA9, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        chk("mid_rst_odata", O_AXIS_TDATA,
            w64(32'h9ABCDEF0, 32'h0FEDCBA9));
        chk("mid_rst_last", 64'({O_AXIS_TVALID, O_AXIS_TLAST}), 64'd3);
        @(posedge clk);
        #1;

        acc_prev = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!I_AXIS_TVALID || acc_prev) begin
                I_AXIS_TVALID = ($urandom_range(0, 2) != 0);
                I_AXIS_TDATA  = $urandom;
                I_AXIS_TSTRB  = 4'($urandom);
                I_AXIS_TKEEP  = 1'($urandom);
                I_AXIS_TLAST  = ($urandom_range(0, 3) == 0);
            end
            O_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_prev = I_AXIS_TVALID & I_AXIS_TREADY;
            @(posedge clk);
            #1;
        end
        I_AXIS_TVALID = 1'b0;
        O_AXIS_TREADY = 1'b1;
        send(32'hC0DEC0DE, 4'hF, 1'b1, 1'b1);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain_q", 64'(q.size()), 64'd0);
        chk("drain_half", 64'(have_lo), 64'd0);
        chk("drain_ovalid", 64'(O_AXIS_TVALID), 64'd0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
